// File: rtl/my_full_adder_pkg.sv
// Shared constants and types for the registered ripple-carry adder.
package my_full_adder_pkg;

  // Widest operand the adder supports.
  localparam int unsigned MAX_WIDTH = 64;

  // Result of one addition: carry out of the MSB followed by the sum bits.
  // The sum field is sized for the widest adder. Narrower adders place their
  // sum in the low bits and leave the rest zero.
  typedef struct packed {
    logic                 carry;
    logic [MAX_WIDTH-1:0] sum;
  } result_t;

endpackage

// File: rtl/my_full_adder_full_adder_cell.sv
// One-bit combinational full adder. The top module chains WIDTH of these.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // sum is the odd-parity of the three inputs; carry is their majority
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/my_full_adder.sv
// Registered WIDTH-bit ripple-carry adder: {carry,sum} = a + b + c_in,
// loaded one cycle after the operands are presented.
//
// Optional build macro: MY_FULL_ADDER_OVF_EN adds the ovf output, the
// two's-complement overflow of the registered result.
//
// Handshake: in_vld qualifies a, b and c_in in the cycle it is high. There is
// no ready signal because the adder accepts one operand set every cycle. The
// result appears on sum/carry with out_vld high exactly one cycle later. When
// in_vld is low, the operands are ignored, the result registers hold their
// contents, and out_vld is low.
module my_full_adder
  import my_full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_vld,
  output logic [WIDTH-1:0] sum,
`ifdef MY_FULL_ADDER_OVF_EN
  output logic             carry,
  output logic             ovf
`else
  output logic             carry
`endif
);

  // Carry chain: c[0] is the external carry-in, c[WIDTH] is the carry out.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  logic [WIDTH-1:0] sum_d,   sum_q;
  logic             carry_d, carry_q;
  logic             vld_d,   vld_q;
`ifdef MY_FULL_ADDER_OVF_EN
  logic             ovf_d,   ovf_q;
`endif

  // Load a fresh result on a valid cycle. Otherwise hold the result, so
  // unqualified (possibly X) operands never reach the registers.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    vld_d   = 1'b0;
`ifdef MY_FULL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (in_vld) begin
      sum_d   = s;
      carry_d = c[WIDTH];
      vld_d   = 1'b1;
`ifdef MY_FULL_ADDER_OVF_EN
      // Signed overflow: the carry into the sign bit differs from the carry out.
      ovf_d   = c[WIDTH] ^ c[WIDTH-1];
`endif
    end
  end

  // Output registers. Synchronous reset wins over a valid in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      vld_q   <= 1'b0;
`ifdef MY_FULL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      vld_q   <= vld_d;
`ifdef MY_FULL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum     = sum_q;
  assign carry   = carry_q;
  assign out_vld = vld_q;
`ifdef MY_FULL_ADDER_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_my_full_adder.sv
// Self-checking bench for my_full_adder at WIDTH = 1, 4 and 8.
// The reference model works with plain integer arithmetic on a + b + c_in.
module tb_my_full_adder;
  import my_full_adder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT signals ----------------
  logic       v1, a1, b1, ci1, ov1, s1, co1;
  logic       v4, ci4, ov4, co4;
  logic [3:0] a4, b4, s4;
  logic       v8, ci8, ov8, co8;
  logic [7:0] a8, b8, s8;
`ifdef MY_FULL_ADDER_OVF_EN
  logic       f1, f4, f8;
`endif

  int checks   = 0;
  int failures = 0;

  localparam int EW = $bits(result_t) + 2;
  logic [EW-1:0] exp_q[$];

  my_full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_vld(v1), .a(a1), .b(b1), .c_in(ci1),
    .out_vld(ov1), .sum(s1),
`ifdef MY_FULL_ADDER_OVF_EN
    .ovf(f1),
`endif
    .carry(co1));

  my_full_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_vld(v4), .a(a4), .b(b4), .c_in(ci4),
    .out_vld(ov4), .sum(s4),
`ifdef MY_FULL_ADDER_OVF_EN
    .ovf(f4),
`endif
    .carry(co4));

  my_full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_vld(v8), .a(a8), .b(b8), .c_in(ci8),
    .out_vld(ov8), .sum(s8),
`ifdef MY_FULL_ADDER_OVF_EN
    .ovf(f8),
`endif
    .carry(co8));

  // ---------------- reference model ----------------
  // Two's-complement overflow: the true signed sum of the operands does not
  // fit in w bits.
  function automatic logic ovf_ref(input int w, input int ua, input int ub, input int ci);
    int half, sa, sb, tot;
    half = 1 << (w - 1);
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    tot  = sa + sb + ci;
    return (tot > half - 1) || (tot < -half);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
    v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1;
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({ov1, co1, s1} !== 3'b000) begin
        failures++;
        $display("FAIL reset_w1 cycle %0d: got vld/carry/sum=%b required 000", k, {ov1, co1, s1});
      end
      checks++;
      if ({ov4, co4, s4} !== 6'b0) begin
        failures++;
        $display("FAIL reset_w4 cycle %0d: got %b required 000000", k, {ov4, co4, s4});
      end
      checks++;
      if ({ov8, co8, s8} !== 10'b0) begin
        failures++;
        $display("FAIL reset_w8 cycle %0d: got %b required 0", k, {ov8, co8, s8});
      end
`ifdef MY_FULL_ADDER_OVF_EN
      checks++;
      if ({f1, f4, f8} !== 3'b000) begin
        failures++;
        $display("FAIL reset_ovf cycle %0d: got %b required 000", k, {f1, f4, f8});
      end
`endif
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_all();
  endtask

  task automatic test_truth_table();
    for (int k = 0; k < 8; k++) begin
      int tot;
      logic [2:0] pat;
      logic [1:0] exp_cs;
      pat = 3'(k);
      @(negedge clk);
      v1 = 1'b1; ci1 = pat[2]; a1 = pat[1]; b1 = pat[0];
      tot = int'(a1) + int'(b1) + int'(ci1);
      exp_cs = 2'(tot);
      @(posedge clk); #1;
      checks++;
      if ({ov1, co1, s1} !== {1'b1, exp_cs}) begin
        failures++;
        $display("FAIL truth_w1 cin,a,b=%b: got vld/carry/sum=%b required %b", pat, {ov1, co1, s1}, {1'b1, exp_cs});
      end
`ifdef MY_FULL_ADDER_OVF_EN
      checks++;
      if (f1 !== ovf_ref(1, int'(pat[1]), int'(pat[0]), int'(pat[2]))) begin
        failures++;
        $display("FAIL truth_w1_ovf cin,a,b=%b: got %b", pat, f1);
      end
`endif
    end
    @(negedge clk);
    v1 = 1'b0;
  endtask

  // Full ripple, overflow and the all-ones/all-zeros corners at WIDTH=4.
  task automatic test_width4_vectors();
    logic [8:0] vec [6];
    vec[0] = {4'hF, 4'h0, 1'b1};
    vec[1] = {4'h7, 4'h1, 1'b0};
    vec[2] = {4'hF, 4'hF, 1'b1};
    vec[3] = {4'h0, 4'h0, 1'b0};
    vec[4] = {4'h8, 4'h8, 1'b0};
    vec[5] = {4'h5, 4'hA, 1'b1};
    for (int k = 0; k < 6; k++) begin
      int tot;
      logic [4:0] exp_cs;
      @(negedge clk);
      v4 = 1'b1; a4 = vec[k][8:5]; b4 = vec[k][4:1]; ci4 = vec[k][0];
      tot = int'(a4) + int'(b4) + int'(ci4);
      exp_cs = 5'(tot);
      @(posedge clk); #1;
      checks++;
      if ({ov4, co4, s4} !== {1'b1, exp_cs}) begin
        failures++;
        $display("FAIL vec_w4 %h+%h+%b: got vld/carry/sum=%b required %b", a4, b4, ci4, {ov4, co4, s4}, {1'b1, exp_cs});
      end
`ifdef MY_FULL_ADDER_OVF_EN
      checks++;
      if (f4 !== ovf_ref(4, int'(a4), int'(b4), int'(ci4))) begin
        failures++;
        $display("FAIL vec_w4_ovf %h+%h+%b: got %b", a4, b4, ci4, f4);
      end
`endif
    end
    @(negedge clk);
    v4 = 1'b0;
  endtask

  // A valid result followed by idle cycles with changing / unknown operands.
  task automatic test_hold();
    @(negedge clk);
    v4 = 1'b1; a4 = 4'h7; b4 = 4'h1; ci4 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ov4, co4, s4} !== 6'b1_0_1000) begin
      failures++;
      $display("FAIL hold_load: got %b required 101000", {ov4, co4, s4});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      v4 = 1'b0;
      if (k == 0) begin a4 = 4'hx; b4 = 4'hx; ci4 = 1'bx; end
      else begin a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom); end
      @(posedge clk); #1;
      checks++;
      if ({ov4, co4, s4} !== 6'b0_0_1000) begin
        failures++;
        $display("FAIL hold_idle cycle %0d: got %b required 001000", k, {ov4, co4, s4});
      end
`ifdef MY_FULL_ADDER_OVF_EN
      checks++;
      if (f4 !== 1'b1) begin
        failures++;
        $display("FAIL hold_ovf cycle %0d: got %b required 1", k, f4);
      end
`endif
    end
  endtask

  // Random back-to-back stream with occasional idle gaps at WIDTH=8.
  task automatic test_random_stream();
    result_t held;
    logic    held_ovf;
    held     = '{carry: co8, sum: MAX_WIDTH'(s8)};
    held_ovf = 1'b0;
`ifdef MY_FULL_ADDER_OVF_EN
    held_ovf = f8;
`endif
    for (int k = 0; k < 300; k++) begin
      logic [EW-1:0] e;
      result_t act;
      int tot;
      @(negedge clk);
      v8  = ($urandom_range(0, 4) != 0);
      a8  = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      if (k % 50 == 7) begin a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; v8 = 1'b1; end
      if (k % 50 == 8) begin a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0; v8 = 1'b1; end
      if (v8) begin
        tot      = int'(a8) + int'(b8) + int'(ci8);
        held     = '{carry: tot[8], sum: MAX_WIDTH'(tot[7:0])};
        held_ovf = ovf_ref(8, int'(a8), int'(b8), int'(ci8));
      end
      exp_q.push_back({v8, held_ovf, held});
      @(posedge clk); #1;
      e   = exp_q.pop_front();
      act = '{carry: co8, sum: MAX_WIDTH'(s8)};
      checks++;
      if ({ov8, act} !== {e[EW-1], e[EW-3:0]}) begin
        failures++;
        $display("FAIL stream_w8 step %0d: got vld=%b carry=%b sum=%h required vld=%b carry=%b sum=%h",
                 k, ov8, act.carry, act.sum, e[EW-1], e[EW-3], e[MAX_WIDTH-1:0]);
      end
`ifdef MY_FULL_ADDER_OVF_EN
      checks++;
      if (f8 !== e[EW-2]) begin
        failures++;
        $display("FAIL stream_w8_ovf step %0d: got %b required %b", k, f8, e[EW-2]);
      end
`endif
    end
    @(negedge clk);
    v8 = 1'b0;
  endtask

  // Reset in the middle of a stream, then a valid right after release.
  task automatic test_reset_midstream();
    @(negedge clk);
    v8 = 1'b1; a8 = 8'h3C; b8 = 8'hC4; ci8 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ov8, co8, s8} !== {1'b1, 9'h101}) begin
      failures++;
      $display("FAIL midrst_pre: got %b required %b", {ov8, co8, s8}, {1'b1, 9'h101});
    end
    @(negedge clk);
    rst_n = 1'b0; a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ov8, co8, s8} !== 10'b0) begin
      failures++;
      $display("FAIL midrst_clear: got %b required 0", {ov8, co8, s8});
    end
    @(negedge clk);
    rst_n = 1'b1; a8 = 8'h80; b8 = 8'h81; ci8 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ov8, co8, s8} !== {1'b1, 9'h101}) begin
      failures++;
      $display("FAIL midrst_first: got %b required %b", {ov8, co8, s8}, {1'b1, 9'h101});
    end
    @(negedge clk);
    v8 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ov8 !== 1'b0) begin
      failures++;
      $display("FAIL midrst_drop: got out_vld=%b required 0", ov8);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    idle_all();
    a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
    a4 = '0; b4 = '0; ci4 = 1'b0;
    a8 = '0; b8 = '0; ci8 = 1'b0;
    test_reset();
    test_truth_table();
    test_width4_vectors();
    test_hold();
    test_random_stream();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
